// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizing and helpers for the FIFO write-port arbiter.
// Derived widths come from cw(), so parameterised modules can size themselves the same way.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Counter/index width, never narrower than one bit.
    function automatic int unsigned cw(input int unsigned v);
        return ($clog2(v) < 1) ? 32'd1 : $clog2(v);
    endfunction

    function automatic int unsigned slice_off(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    localparam int unsigned DEF_N         = 32'd4;
    localparam int unsigned DEF_W         = 32'd16;
    localparam int unsigned DEF_MAX_BURST = 32'd8;
    localparam int unsigned DEF_TIMEOUT   = 32'd4;

    localparam int unsigned GRANT_W = cw(DEF_N);
    localparam int unsigned BEAT_W  = cw(DEF_MAX_BURST + 32'd1);
    localparam int unsigned IDLE_W  = cw(DEF_TIMEOUT + 32'd1);

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]       req,
    input  logic [cw(N)-1:0]   ptr,
    output logic               found,
    output logic [cw(N)-1:0]   idx
);

    localparam int unsigned GW = cw(N);

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end else begin
                j = j;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = GW'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among N producers.
// The write path is combinational from the granted requester; control state is registered.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                             write_clk,
    input  logic                             reset,
    input  logic [N-1:0]                     req_valid,
    input  logic [N-1:0]                     req_last,
    input  logic [N*W-1:0]                   req_data,
    output logic [N-1:0]                     req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_wr_en,
    output logic [W-1:0]                     fifo_wr_data,
    output logic [cw(N)-1:0]                 grant_id,
    output logic                             busy,
    output logic [cw(MAX_BURST+32'd1)-1:0]   beat_count
);

    localparam int unsigned GW = cw(N);
    localparam int unsigned BW = cw(MAX_BURST + 32'd1);
    localparam int unsigned IW = cw(TIMEOUT + 32'd1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(MAX_BURST - 32'd1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 32'd1);
    localparam logic [GW-1:0] LAST_ID    = GW'(N - 32'd1);

    arb_state_t       state_r, state_s;
    logic [GW-1:0]    rr_ptr_r, rr_ptr_s;
    logic [GW-1:0]    grant_r, grant_s;
    logic [BW-1:0]    beat_r, beat_s;
    logic [IW-1:0]    idle_r, idle_s;
    logic             pick_found_s;
    logic [GW-1:0]    pick_idx_s;
    logic             rel_s;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Control state registers; reset abandons any burst in flight.
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            beat_r   <= '0;
            idle_r   <= '0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            grant_r  <= grant_s;
            beat_r   <= beat_s;
            idle_r   <= idle_s;
        end
    end

    // Next-state logic and the pass-through write path.
    always_comb begin
        state_s      = state_r;
        rr_ptr_s     = rr_ptr_r;
        grant_s      = grant_r;
        beat_s       = beat_r;
        idle_s       = idle_r;
        rel_s        = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s = ST_BURST;
                    grant_s = pick_idx_s;
                    beat_s  = '0;
                    idle_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                req_ready[grant_r] = ~fifo_full;
                fifo_wr_en         = req_valid[grant_r] & ~fifo_full;
                if (fifo_wr_en) begin
                    fifo_wr_data = req_data[slice_off(32'(grant_r), W) +: W];
                    beat_s       = beat_r + BW'(1);
                    idle_s       = '0;
                    rel_s        = req_last[grant_r] | (beat_r == LAST_BEAT);
                end else if (!req_valid[grant_r]) begin
                    idle_s = idle_r + IW'(1);
                    rel_s  = (idle_r == IDLE_LIMIT);
                end else begin
                    // Backpressure stall: both counters hold.
                    idle_s = idle_r;
                end
                if (rel_s) begin
                    state_s  = ST_IDLE;
                    grant_s  = '0;
                    rr_ptr_s = (grant_r == LAST_ID) ? '0 : grant_r + GW'(1);
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign grant_id   = grant_r;
    assign busy       = (state_r == ST_BURST);
    assign beat_count = beat_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised + directed bench for fifo_write_arbiter: a cycle-level behavioural model
// feeds an expected-write queue that a separate monitor drains on every FIFO write.
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int MAX_BURST = 8;
    localparam int TIMEOUT = 4;

    logic           write_clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [3:0]     beat_count;

    fifo_write_arbiter #(.N(N), .W(W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .write_clk    (write_clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .beat_count   (beat_count)
    );

    initial begin
        write_clk = 1'b0;
        forever #5 write_clk = ~write_clk;
    end

    int checks = 0;
    int errors = 0;
    int writes_exp = 0;
    int writes_dut = 0;
    logic [W-1:0] wq[$];
    int glog[$];
    int blog[$];
    logic prev_busy = 1'b0;

    // Reference model: owner -1 means nobody holds the port.
    int m_owner = -1;
    int m_ptr = 0;
    int m_beats = 0;
    int m_idle = 0;
    logic [W-1:0] dat [N];
    bit rand_data = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT write must match the oldest model-predicted write.
    always @(negedge write_clk) begin
        if (fifo_wr_en === 1'b1) begin
            writes_dut++;
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("wr_data", 32'(fifo_wr_data), 32'(wq.pop_front()));
            end
        end
    end

    task automatic model_reset();
        m_owner = -1;
        m_ptr = 0;
        m_beats = 0;
        m_idle = 0;
    endtask

    // One clock cycle: drive, predict, check combinational outputs, clock, check state.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        logic [N-1:0] e_ready;
        logic e_en;
        logic [W-1:0] e_data;
        int acc;
        e_ready = '0;
        e_en = 1'b0;
        e_data = '0;
        acc = -1;
        req_valid = v;
        req_last = l;
        fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (v[c] && m_owner < 0) begin
                    m_owner = c;
                    m_beats = 0;
                    m_idle = 0;
                end
            end
        end else begin
            int o;
            bit done;
            o = m_owner;
            done = 1'b0;
            e_ready[o] = !f;
            e_en = v[o] && !f;
            if (e_en) begin
                e_data = dat[o];
                wq.push_back(dat[o]);
                writes_exp++;
                acc = o;
                m_beats++;
                m_idle = 0;
                done = l[o] || (m_beats == MAX_BURST);
            end else if (!v[o]) begin
                m_idle++;
                done = (m_idle == TIMEOUT);
            end
            if (done) begin
                m_ptr = (o + 1) % N;
                m_owner = -1;
            end
        end
        #1;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_en));
        chk("fifo_wr_data_comb", 32'(fifo_wr_data), 32'(e_data));
        @(posedge write_clk);
        #1;
        chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("beat_count", 32'(beat_count), 32'(m_beats));
        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        if (!busy && prev_busy) blog.push_back(int'(beat_count));
        prev_busy = busy;
        if (acc >= 0) dat[acc] = rand_data ? W'($urandom) : dat[acc] + 16'h0005;
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_beats", 32'(beat_count), 32'd0);
        model_reset();
        prev_busy = 1'b0;
        @(posedge write_clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = W'(16'h0100 * i + 16'h0005);
        do_reset();

        // Single requester, three beats 5/A/F, last on the third.
        dat[2] = 16'h0005;
        step(4'b0100, 4'b0000, 1'b0);
        chk("t1_grant", 32'(grant_id), 32'd2);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_beats", 32'(beat_count), 32'd3);
        step(4'b0101, 4'b0000, 1'b0);
        chk("t1_ptr_after_2", 32'(grant_id), 32'd0);

        // All four request continuously with no last.
        do_reset();
        glog.delete();
        blog.delete();
        for (int c = 0; c < 60 && glog.size() < 5; c++) step(4'b1111, 4'b0000, 1'b0);
        chk("t2_grant_count", 32'(glog.size()), 32'd5);
        for (int g = 0; g < 5 && g < glog.size(); g++) chk("t2_grant_order", 32'(glog[g]), 32'(g % N));
        for (int g = 0; g < 4 && g < blog.size(); g++) chk("t2_release_beats", 32'(blog[g]), 32'd8);

        // Backpressure for five cycles mid-burst of requester 1.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) step(4'b0010, 4'b0000, 1'b1);
        chk("t3_no_timeout", 32'(busy), 32'd1);
        chk("t3_beats_held", 32'(beat_count), 32'd2);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0010, 1'b0);
        chk("t3_total_beats", 32'(beat_count), 32'd4);

        // Timeout: requester 3 sends two beats then goes quiet.
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 1'b0);
        chk("t4_still_busy", 32'(busy), 32'd1);
        step(4'b0000, 4'b0000, 1'b0);
        chk("t4_released", 32'(busy), 32'd0);
        chk("t4_beats_held", 32'(beat_count), 32'd2);
        step(4'b1001, 4'b0000, 1'b0);
        chk("t4_ptr_wrap", 32'(grant_id), 32'd0);

        // Reset in the middle of a burst from requester 0.
        do_reset();
        step(4'b0001, 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) step(4'b0001, 4'b0000, 1'b0);
        do_reset();
        step(4'b0011, 4'b0000, 1'b0);
        chk("t5_grant_after_reset", 32'(grant_id), 32'd0);

        // Last coinciding with the eighth beat.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0);
        for (int c = 0; c < 7; c++) step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        chk("t6_one_release", 32'(busy), 32'd0);
        chk("t6_beats", 32'(beat_count), 32'd8);
        step(4'b1100, 4'b0000, 1'b0);
        chk("t6_next_owner", 32'(grant_id), 32'd3);

        // Randomised traffic with occasional resets.
        rand_data = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] v;
            logic [N-1:0] l;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                l[i] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            step(v, l, ($urandom_range(0, 4) == 0));
        end

        req_valid = '0;
        @(posedge write_clk);
        #1;
        chk("queue_drained", 32'(wq.size()), 32'd0);
        chk("write_count", 32'(writes_dut), 32'(writes_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
